// File: rtl/arb_pkg.sv
// Shared types and helpers for the arb component's round-robin arbiters.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        OUT   = 2'd2
    } arb_state_t;

    // Wrap-around increment of a port index in the range [0, n).
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first requester after lastGrant, with wrap.
module rr_picker
    import arb_pkg::*;
#(
    parameter int unsigned  NUM_PORTS = 4,
    localparam int unsigned PORT_W    = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PORT_W-1:0]    lastGrant,
    output logic [PORT_W-1:0]    pick,
    output logic                 anyReq
);

    logic [2*NUM_PORTS-1:0] req_dbl;
    logic [NUM_PORTS-1:0]   req_rot;
    int unsigned            start;
    int unsigned            offset;

    // Rotate so the search starts at lastGrant+1, priority-encode, then un-rotate.
    always_comb begin
        start   = rr_next(32'(lastGrant), NUM_PORTS);
        req_dbl = {req, req};
        req_rot = NUM_PORTS'(req_dbl >> start);
        offset  = 32'd0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                offset = 32'(i);
            end
        end
        pick = PORT_W'((start + offset) % NUM_PORTS);
    end

    assign anyReq = |req;

endmodule

// File: rtl/fifo_rr_arb.sv
// Round-robin read arbiter draining NUM_PORTS one-cycle-latency FIFOs into a valid/ready stream.
module fifo_rr_arb
    import arb_pkg::*;
#(
    parameter int unsigned  NUM_PORTS  = 4,
    parameter int unsigned  DATA_WIDTH = 8,
    localparam int unsigned PORT_W     = $clog2(NUM_PORTS)
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [NUM_PORTS-1:0]            emptyIn,
    output logic [NUM_PORTS-1:0]            rdEnOut,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] rdDataIn,
    output logic                            outValid,
    input  logic                            outReady,
    output logic [DATA_WIDTH-1:0]           outData,
    output logic [PORT_W-1:0]               outPort,
    output logic                            busy
);

    arb_state_t            state_q, state_d;
    logic [PORT_W-1:0]     sel_port_q, sel_port_d;
    logic [PORT_W-1:0]     last_grant_q, last_grant_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [PORT_W-1:0]     out_port_q, out_port_d;
    logic                  out_valid_q, out_valid_d;

    logic [PORT_W-1:0]     pick;
    logic                  any_req;
    logic                  issue;
    logic [DATA_WIDTH-1:0] rd_words [NUM_PORTS];

    rr_picker #(
        .NUM_PORTS (NUM_PORTS)
    ) u_picker (
        .req       (~emptyIn),
        .lastGrant (last_grant_q),
        .pick      (pick),
        .anyReq    (any_req)
    );

    // Unflatten the FIFO read-data bus into one word per port.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            rd_words[i] = rdDataIn[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Next-state and datapath: issue a pop, capture the returned word, hold until accepted.
    always_comb begin
        state_d      = state_q;
        sel_port_d   = sel_port_q;
        last_grant_d = last_grant_q;
        out_data_d   = out_data_q;
        out_port_d   = out_port_q;
        out_valid_d  = out_valid_q;
        issue        = 1'b0;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    issue   = 1'b1;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                out_data_d  = rd_words[sel_port_q];
                out_port_d  = sel_port_q;
                out_valid_d = 1'b1;
                state_d     = OUT;
            end
            OUT: begin
                // The accepting cycle may already pop the next word.
                if (outReady) begin
                    out_valid_d = 1'b0;
                    if (any_req) begin
                        issue   = 1'b1;
                        state_d = FETCH;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (issue) begin
            sel_port_d   = pick;
            last_grant_d = pick;
        end
    end

    // Single-cycle read pulse to the granted FIFO.
    always_comb begin
        rdEnOut = '0;
        if (issue) begin
            rdEnOut[pick] = 1'b1;
        end
    end

    // State and output registers; lastGrant resets to the top port so port 0 wins first.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            sel_port_q   <= '0;
            last_grant_q <= PORT_W'(NUM_PORTS - 1);
            out_data_q   <= '0;
            out_port_q   <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_port_q   <= sel_port_d;
            last_grant_q <= last_grant_d;
            out_data_q   <= out_data_d;
            out_port_q   <= out_port_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign outValid = out_valid_q;
    assign outData  = out_data_q;
    assign outPort  = out_port_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_rr_arb.sv
// Self-checking bench for fifo_rr_arb with behavioural FIFO model and scoreboard.
module tb_fifo_rr_arb;

    localparam int NP    = 4;
    localparam int DW    = 8;
    localparam int PW    = 2;
    localparam int DEPTH = 256;

    logic              clock    = 1'b0;
    logic              reset    = 1'b0;
    logic [NP-1:0]     emptyIn  = '1;
    logic [NP-1:0]     rdEnOut;
    logic [NP*DW-1:0]  rdDataIn = '0;
    logic              outValid;
    logic              outReady = 1'b0;
    logic [DW-1:0]     outData;
    logic [PW-1:0]     outPort;
    logic              busy;

    fifo_rr_arb #(
        .NUM_PORTS  (NP),
        .DATA_WIDTH (DW)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .emptyIn  (emptyIn),
        .rdEnOut  (rdEnOut),
        .rdDataIn (rdDataIn),
        .outValid (outValid),
        .outReady (outReady),
        .outData  (outData),
        .outPort  (outPort),
        .busy     (busy)
    );

    always #5 clock = ~clock;

    int unsigned nvec = 0;
    int unsigned nerr = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nvec++;
        if (obs !== expv) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, expv, $time);
        end
    endtask

    // Upstream FIFO contents: written by stimulus, popped by the model process.
    logic [DW-1:0] mem [NP][DEPTH];
    int            wr_ptr [NP];
    int            rd_ptr [NP];

    task automatic push(input int p, input logic [DW-1:0] d);
        mem[p][wr_ptr[p] % DEPTH] = d;
        wr_ptr[p]++;
    endtask

    function automatic int pending();
        int s = 0;
        for (int i = 0; i < NP; i++) s += wr_ptr[i] - rd_ptr[i];
        return s;
    endfunction

    // Round-robin rule: first non-empty port after the last grant, wrapping.
    function automatic int rr_expect(input int last, input logic [NP-1:0] emp);
        for (int k = 1; k <= NP; k++) begin
            if (!emp[(last + k) % NP]) return (last + k) % NP;
        end
        return -1;
    endfunction

    // Model / scoreboard state
    int               m_last = NP - 1;
    logic [PW+DW-1:0] sb [$];
    int               pulse_log [$];
    int               hs_log [$];
    int               hs_cyc [$];
    int               cyc = 0;
    bit               h1 = 0, h2 = 0;
    bit               pv_valid = 0, pv_ready = 0;
    logic [DW-1:0]    pv_data = '0;
    logic [PW-1:0]    pv_port = '0;

    // FIFO model plus per-cycle protocol checks, evaluated on pre-edge values.
    initial begin
        forever begin
            @(posedge clock or negedge reset);
            if (!reset) begin
                for (int i = 0; i < NP; i++) rd_ptr[i] = wr_ptr[i];
                emptyIn  <= '1;
                rdDataIn <= '0;
                sb.delete();
                m_last   = NP - 1;
                h1       = 0;
                h2       = 0;
                pv_valid = 0;
            end else begin
                int              pulse;
                logic            anyreq;
                logic [NP-1:0]   ne;
                logic [PW+DW-1:0] e;
                cyc++;
                pulse  = -1;
                anyreq = |(~emptyIn);
                for (int i = 0; i < NP; i++) if (rdEnOut[i]) pulse = i;
                check_eq("rd_onehot0", 32'($countones(rdEnOut) <= 1), 1);
                if (h1) check_eq("fetch_gap_valid", outValid, 0);
                if (h2) check_eq("latency_valid", outValid, 1);
                if (pv_valid && !pv_ready) begin
                    check_eq("hold_valid", outValid, 1);
                    check_eq("hold_data", outData, pv_data);
                    check_eq("hold_port", outPort, pv_port);
                end
                if (outValid) check_eq("sb_depth", sb.size(), 1);
                if (outValid && !outReady) check_eq("no_rd_stall", rdEnOut, 0);
                if (!outValid && sb.size() == 0 && anyreq) check_eq("idle_issue", |rdEnOut, 1);
                if (outValid && outReady) begin
                    check_eq("b2b_issue", |rdEnOut, anyreq);
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        check_eq("hs_data", outData, e[DW-1:0]);
                        check_eq("hs_port", outPort, e[PW+DW-1:DW]);
                    end
                    hs_log.push_back(int'(outPort));
                    hs_cyc.push_back(cyc);
                end
                if (pulse >= 0) begin
                    check_eq("pop_nonempty", emptyIn[pulse], 0);
                    check_eq("rr_pick", pulse, rr_expect(m_last, emptyIn));
                    m_last = pulse;
                    sb.push_back({PW'(pulse), mem[pulse][rd_ptr[pulse] % DEPTH]});
                    pulse_log.push_back(pulse);
                    rdDataIn[pulse*DW +: DW] <= mem[pulse][rd_ptr[pulse] % DEPTH];
                    rd_ptr[pulse]++;
                end
                h2       = h1;
                h1       = (pulse >= 0);
                pv_valid = outValid;
                pv_ready = outReady;
                pv_data  = outData;
                pv_port  = outPort;
                for (int i = 0; i < NP; i++) ne[i] = (wr_ptr[i] == rd_ptr[i]);
                emptyIn <= ne;
            end
        end
    end

    task automatic wait_idle(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (!busy && !outValid && pending() == 0) break;
        end
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_pending"}, pending(), 0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Directed scenarios followed by randomized traffic.
    initial begin
        int s, pushes;
        logic [DW-1:0] sd;
        logic [PW-1:0] sp;

        // Reset values
        repeat (3) @(negedge clock);
        check_eq("rst_rden", rdEnOut, 0);
        check_eq("rst_valid", outValid, 0);
        check_eq("rst_data", outData, 0);
        check_eq("rst_port", outPort, 0);
        check_eq("rst_busy", busy, 0);

        // First transaction latency from FIFO0
        reset    = 1'b1;
        outReady = 1'b1;
        push(0, 8'hA5);
        @(negedge clock);
        check_eq("t1_rden", rdEnOut, 4'b0001);
        @(negedge clock);
        check_eq("t1_fetch_valid", outValid, 0);
        check_eq("t1_fetch_busy", busy, 1);
        @(negedge clock);
        check_eq("t1_valid", outValid, 1);
        check_eq("t1_data", outData, 8'hA5);
        check_eq("t1_port", outPort, 0);
        wait_idle("t1_idle", 10);

        // All four FIFOs with three words: strict rotation, one word per two cycles
        do_reset();
        for (int k = 0; k < 3; k++)
            for (int p = 0; p < NP; p++) push(p, 8'(16 * p + k + 1));
        s = hs_log.size();
        for (int i = 0; i < 10 && !busy; i++) @(negedge clock);
        check_eq("t2_busy_start", busy, 1);
        for (int i = 0; i < 60; i++) begin
            if (hs_log.size() >= s + 12) break;
            check_eq("t2_busy", busy, 1);
            @(negedge clock);
        end
        check_eq("t2_count", hs_log.size() - s, 12);
        for (int i = 0; i < 12 && s + i < hs_log.size(); i++) begin
            check_eq("t2_port_seq", hs_log[s+i], i % NP);
            if (i > 0) check_eq("t2_spacing", hs_cyc[s+i] - hs_cyc[s+i-1], 2);
        end
        wait_idle("t2_idle", 10);

        // Ports 1 and 3 only, with lastGrant = 1
        push(1, 8'h11);
        wait_idle("t3_prep", 10);
        s = pulse_log.size();
        push(1, 8'h12); push(1, 8'h13);
        push(3, 8'h31); push(3, 8'h32);
        wait_idle("t3_idle", 40);
        check_eq("t3_count", pulse_log.size() - s, 4);
        for (int i = 0; i < 4 && s + i < pulse_log.size(); i++)
            check_eq("t3_grant", pulse_log[s+i], (i % 2 == 0) ? 3 : 1);

        // Backpressure for 10 cycles in OUT
        outReady = 1'b0;
        push(0, 8'h3C);
        push(2, 8'hC3);
        for (int i = 0; i < 10 && !outValid; i++) @(negedge clock);
        check_eq("t4_valid", outValid, 1);
        check_eq("t4_first_port", outPort, 2);
        sd = outData;
        sp = outPort;
        repeat (10) begin
            @(negedge clock);
            check_eq("t4_hold_data", outData, sd);
            check_eq("t4_hold_port", outPort, sp);
            check_eq("t4_no_rd", rdEnOut, 0);
        end
        outReady = 1'b1;
        #1;
        check_eq("t4_resume_issue", rdEnOut, 4'b0001);
        wait_idle("t4_idle", 20);

        // Asynchronous reset while in FETCH
        push(1, 8'h5A);
        push(3, 8'h6B);
        for (int i = 0; i < 10 && rdEnOut == 0; i++) @(negedge clock);
        check_eq("t5_pulse", |rdEnOut, 1);
        @(negedge clock);
        check_eq("t5_in_fetch", busy, 1);
        reset = 1'b0;
        #1;
        check_eq("t5_rst_rden", rdEnOut, 0);
        check_eq("t5_rst_valid", outValid, 0);
        check_eq("t5_rst_data", outData, 0);
        check_eq("t5_rst_port", outPort, 0);
        check_eq("t5_rst_busy", busy, 0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        s = pulse_log.size();
        push(2, 8'h77);
        push(0, 8'h66);
        wait_idle("t5_idle", 20);
        check_eq("t5_count", pulse_log.size() - s, 2);
        if (pulse_log.size() >= s + 2) begin
            check_eq("t5_restart_port", pulse_log[s], 0);
            check_eq("t5_second_port", pulse_log[s+1], 2);
        end

        // Random pushes and backpressure, then drain
        s = hs_log.size();
        pushes = 0;
        repeat (3000) begin
            @(negedge clock);
            outReady = ($urandom_range(0, 3) != 0);
            for (int p = 0; p < NP; p++) begin
                if (wr_ptr[p] - rd_ptr[p] < 8 && $urandom_range(0, 3) == 0) begin
                    push(p, 8'($urandom));
                    pushes++;
                end
            end
        end
        outReady = 1'b1;
        wait_idle("rand_drain", 200);
        check_eq("rand_words_out", hs_log.size() - s, pushes);
        check_eq("rand_sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/fifo_rr_arb.md
# fifo_rr_arb

Round-robin read arbiter that drains NUM_PORTS upstream synchronous FIFOs (BRAM-backed, one-cycle read latency, registered `empty`) into a single valid/ready output stream. Sits directly downstream of the per-source request FIFOs in the arb component. It issues single-cycle read pulses, captures the returned word and tags it with its source port. It holds output data stable under backpressure and never pops a FIFO whose `empty` is high.

## Interface
Parameters:
- `NUM_PORTS`, 4: number of upstream FIFOs; must be ≥2.
- `DATA_WIDTH`, 8: FIFO word width.
- `PORT_W`, `$clog2(NUM_PORTS)`: width of the port tag; derived, not overridden.

Ports:
- `clock`  in  1  single clock.
- `reset`  in  1  asynchronous, active-low reset.
- `emptyIn`  in  NUM_PORTS  per-FIFO empty flag; bit i belongs to FIFO i.
- `rdEnOut`  out  NUM_PORTS  per-FIFO read pulse; at most one bit high in any cycle.
- `rdDataIn`  in  NUM_PORTS*DATA_WIDTH  flattened FIFO read data; port i is in bits [i*DATA_WIDTH +: DATA_WIDTH].
- `outValid`  out  1  output word valid.
- `outReady`  in  1  downstream accepts the word.
- `outData`  out  DATA_WIDTH  output word.
- `outPort`  out  PORT_W  index of the source FIFO for `outData`.
- `busy`  out  1  high when the state is not IDLE.

## Operation
- FSM states: IDLE, FETCH, OUT.
- `req = ~emptyIn`. The pick is the first set bit of `req`, searching upward from `(lastGrant+1) mod NUM_PORTS` with wrap-around.
- `issue` = (state==IDLE && |req) || (state==OUT && outReady && |req).
- `rdEnOut[pick] = issue`, combinational. All other bits are 0.
- On `issue`:
  - `selPort <= pick`, `lastGrant <= pick`, state → FETCH.
  - If issued from OUT, the current word completes its handshake in the same cycle.
- IDLE with `req==0`: stay in IDLE. No pulses.
- FETCH:
  - `outData <= rdDataIn[selPort]`, `outPort <= selPort`, `outValid <= 1`.
  - State → OUT unconditionally.
  - `rdEnOut` is 0.
- OUT:
  - `outValid`=1. `outData` and `outPort` hold until the handshake.
  - `outReady && !|req`: `outValid <= 0`, state → IDLE.
  - `outReady` with `|req`: `issue` path above. `outValid <= 0` for the FETCH cycle.
  - `!outReady`: hold. No read is issued.
- `outReady` while `outValid`=0 is ignored.
- A port whose `emptyIn` rises between pick and FETCH is not possible, because only this block pops. The data captured is the popped word.
- The grant pointer advances only on `issue`. A port that goes empty loses its turn with no penalty.
- Single active requester: that port is granted on every issue.

## Timing
- Reset values:
  - `rdEnOut`=0, `outValid`=0, `outData`=0, `outPort`=0, `busy`=0.
  - State IDLE.
  - `lastGrant`=NUM_PORTS-1, so port 0 wins first.
- `rdEnOut` pulse in cycle T. FIFO data is valid on `rdDataIn` in T+1 (FETCH). `outValid` is high from T+2.
- Latency from a non-empty FIFO in IDLE to `outValid`: 2 cycles.
- Sustained throughput with `outReady` tied high: one word per 2 cycles.
- Reset asserted mid-operation: all state and outputs clear asynchronously. A word in FETCH or OUT is discarded. Upstream FIFOs are reset on the same reset, so the system stays consistent.
- `outValid` never drops without a handshake, except on reset.

## Structure
- `arb_pkg`: `arb_state_t` enum {IDLE, FETCH, OUT} and a `rr_next` helper function for the wrap-around increment.
- Sub-module `rr_picker`: combinational. Inputs are `req` [NUM_PORTS] and `lastGrant`. Outputs are `pick` [PORT_W] and `anyReq`. It implements a rotate, priority-encode, un-rotate search. It is reusable by other arbiters in the component.
- `fifo_rr_arb` holds the FSM, the `selPort`/`lastGrant` registers and the output register.

## Test plan
- Reset, then `emptyIn`=4'b1110 with FIFO0 holding 0xA5 and `outReady`=1:
  - `rdEnOut`=4'b0001 one cycle after reset release.
  - `outValid`=1 with `outData`=0xA5 and `outPort`=0 two cycles later.
- All 4 FIFOs hold 3 words, `outReady`=1:
  - `outPort` sequence is 0,1,2,3,0,1,2,3,0,1,2,3, one word every 2 cycles.
  - `busy` stays high throughout.
- FIFO1 and FIFO3 non-empty, `lastGrant`=1:
  - Next grant is 3, then 1.
  - Ports 0 and 2 never receive `rdEnOut`.
- `outReady`=0 for 10 cycles while in OUT:
  - `outData` and `outPort` are stable.
  - `rdEnOut` stays 0.
  - Raising `outReady` completes the handshake and issues the next read in the same cycle.
- Assert `reset` during FETCH:
  - All outputs are 0 immediately, without waiting for a clock edge.
  - After release, arbitration restarts at port 0.
- Random `emptyIn` and `outReady`, scoreboarded against the FIFO contents:
  - No word is lost or duplicated.
  - `rdEnOut` is never high on a port with `emptyIn`=1.
  - `rdEnOut` is always one-hot or zero.
